// File: rtl/cpu_program_sequencer_pkg.sv
// Shared sequencer definitions: FSM state encoding, default instruction width
// and the hold-counter width helper.
package cpu_seq_defs;

  localparam int SEQ_INSTR_W = 11;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_PAUSE = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // A hold of one clock still needs a 1-bit counter to stay a legal vector.
  function automatic int seq_cyc_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cpu_program_sequencer_seq_prog_mem.sv
// Program store: DEPTH x INSTR_W array with async read, one write port and a
// per-slot valid vector that can be cleared in a single cycle.
module seq_prog_mem #(
  parameter int INSTR_W = 11,
  parameter int DEPTH   = 256,
  parameter int PC_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               clear,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata,
  output logic [DEPTH-1:0]   valid
);

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;

  // Program data is deliberately not reset; valid bits decide what is executable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Valid bits: bulk clear wins over a write in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (clear) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[waddr] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign rdata = mem_r[raddr];
  assign valid = valid_r;

endmodule

// File: rtl/cpu_program_sequencer.sv
// Instruction sequencer for cpu_top: issues each stored instruction for
// CYCLES_PER_INSTR clocks, with free-run, single-step and loop modes.
module cpu_program_sequencer
  import cpu_seq_defs::*;
#(
  parameter int INSTR_W          = SEQ_INSTR_W,
  parameter int DEPTH            = 256,
  parameter int PC_W             = $clog2(DEPTH),
  parameter int CYCLES_PER_INSTR = 3,
  parameter int CNT_W            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_we,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               clear_prog,
  output logic               load_ready,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               loop_en,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               instr_strobe,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int               CYC_W    = seq_cyc_w(CYCLES_PER_INSTR);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DEPTH - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_INSTR - 1);

  seq_state_e         state_r;
  logic [CYC_W-1:0]   cyc_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               instr_strobe_r;
  logic               busy_r;
  logic               done_r;
  logic               load_ready_r;
  logic [CNT_W-1:0]   count_r;

  logic               mem_we_s;
  logic               mem_clear_s;
  logic [PC_W-1:0]    rd_addr_s;
  logic [INSTR_W-1:0] rd_data_s;
  logic [DEPTH-1:0]   valid_s;
  logic [PC_W-1:0]    next_pc_s;
  logic               last_slot_s;
  logic               adv_go_s;
  logic [PC_W-1:0]    adv_pc_s;
  logic               cyc_last_s;

  assign mem_we_s    = load_we && load_ready_r;
  assign mem_clear_s = clear_prog && load_ready_r;
  assign cyc_last_s  = (cyc_r == CYC_LAST);

  seq_prog_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PC_W    (PC_W)
  ) u_prog_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .clear (mem_clear_s),
    .raddr (rd_addr_s),
    .rdata (rd_data_s),
    .valid (valid_s)
  );

  // Decide where execution goes after the current instruction and fetch that slot.
  always_comb begin
    next_pc_s   = pc_r + PC_W'(1);
    last_slot_s = (pc_r == PC_LAST) || !valid_s[next_pc_s];
    adv_go_s    = 1'b0;
    adv_pc_s    = pc_r;
    rd_addr_s   = '0;
    if (!last_slot_s) begin
      adv_go_s = 1'b1;
      adv_pc_s = next_pc_s;
    end else if (loop_en && valid_s[0]) begin
      adv_go_s = 1'b1;
      adv_pc_s = '0;
    end else begin
      adv_go_s = 1'b0;
      adv_pc_s = pc_r;
    end
    if ((state_r == SEQ_ISSUE) || (state_r == SEQ_PAUSE)) begin
      rd_addr_s = adv_pc_s;
    end else begin
      rd_addr_s = '0;
    end
  end

  // Sequencer FSM with all outputs registered; abort overrides every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= SEQ_IDLE;
      cyc_r          <= '0;
      pc_r           <= '0;
      instr_r        <= '0;
      instr_valid_r  <= 1'b0;
      instr_strobe_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      load_ready_r   <= 1'b1;
      count_r        <= '0;
    end else if (abort) begin
      state_r        <= SEQ_IDLE;
      cyc_r          <= '0;
      pc_r           <= '0;
      instr_r        <= '0;
      instr_valid_r  <= 1'b0;
      instr_strobe_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      load_ready_r   <= 1'b1;
    end else begin
      instr_strobe_r <= 1'b0;
      case (state_r)
        SEQ_IDLE, SEQ_DONE: begin
          if (start) begin
            count_r <= '0;
            pc_r    <= '0;
            cyc_r   <= '0;
            if (valid_s[0]) begin
              state_r        <= SEQ_ISSUE;
              instr_r        <= rd_data_s;
              instr_valid_r  <= 1'b1;
              instr_strobe_r <= 1'b1;
              busy_r         <= 1'b1;
              done_r         <= 1'b0;
              load_ready_r   <= 1'b0;
            end else begin
              state_r       <= SEQ_DONE;
              instr_r       <= '0;
              instr_valid_r <= 1'b0;
              busy_r        <= 1'b0;
              done_r        <= 1'b1;
              load_ready_r  <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        SEQ_ISSUE: begin
          if (!cyc_last_s) begin
            cyc_r <= cyc_r + CYC_W'(1);
          end else begin
            cyc_r   <= '0;
            count_r <= count_r + CNT_W'(1);
            if (step_mode) begin
              state_r       <= SEQ_PAUSE;
              instr_valid_r <= 1'b0;
            end else if (adv_go_s) begin
              pc_r           <= adv_pc_s;
              instr_r        <= rd_data_s;
              instr_strobe_r <= 1'b1;
            end else begin
              state_r       <= SEQ_DONE;
              instr_r       <= '0;
              instr_valid_r <= 1'b0;
              busy_r        <= 1'b0;
              done_r        <= 1'b1;
              load_ready_r  <= 1'b1;
            end
          end
        end
        SEQ_PAUSE: begin
          if (step && adv_go_s) begin
            state_r        <= SEQ_ISSUE;
            pc_r           <= adv_pc_s;
            instr_r        <= rd_data_s;
            instr_valid_r  <= 1'b1;
            instr_strobe_r <= 1'b1;
          end else if (step) begin
            state_r      <= SEQ_DONE;
            instr_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            load_ready_r <= 1'b1;
          end else begin
            state_r <= SEQ_PAUSE;
          end
        end
        default: begin
          state_r       <= SEQ_IDLE;
          cyc_r         <= '0;
          pc_r          <= '0;
          instr_r       <= '0;
          instr_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
          load_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign instruction  = instr_r;
  assign instr_valid  = instr_valid_r;
  assign instr_strobe = instr_strobe_r;
  assign pc           = pc_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign load_ready   = load_ready_r;
  assign instr_count  = count_r;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Randomized bench for cpu_program_sequencer against a slot-walking reference model.
module tb_cpu_program_sequencer;

  localparam int DEPTH   = 256;
  localparam int INSTR_W = 11;
  localparam int PC_W    = 8;
  localparam int CYC     = 3;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_we;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               clear_prog;
  logic               load_ready;
  logic               start;
  logic               step_mode;
  logic               step;
  logic               loop_en;
  logic               abort;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               instr_strobe;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   instr_count;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] m_mem [DEPTH];
  bit                 m_valid [DEPTH];

  cpu_program_sequencer #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_W(PC_W),
    .CYCLES_PER_INSTR(CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .clear_prog(clear_prog), .load_ready(load_ready),
    .start(start), .step_mode(step_mode), .step(step), .loop_en(loop_en),
    .abort(abort), .instruction(instruction), .instr_valid(instr_valid),
    .instr_strobe(instr_strobe), .pc(pc), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [INSTR_W-1:0] data);
    load_we = 1'b1; load_addr = PC_W'(addr); load_data = data;
    tick();
    load_we = 1'b0;
    m_mem[addr] = data;
    m_valid[addr] = 1'b1;
  endtask

  task automatic clear_all();
    clear_prog = 1'b1;
    tick();
    clear_prog = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic expect_idle(input int cnt);
    check("idle_done", done, 0);
    check("idle_ivalid", instr_valid, 0);
    check("idle_instr", instruction, 0);
    check("idle_strobe", instr_strobe, 0);
    check("idle_pc", pc, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", load_ready, 1);
    check("idle_count", instr_count, cnt);
  endtask

  task automatic expect_done(input int p, input int cnt);
    for (int r = 0; r < 2; r++) begin
      check("done", done, 1);
      check("done_ivalid", instr_valid, 0);
      check("done_instr", instruction, 0);
      check("done_strobe", instr_strobe, 0);
      check("done_pc", pc, p);
      check("done_busy", busy, 0);
      check("done_ready", load_ready, 1);
      check("done_count", instr_count, cnt);
      if (r == 0) tick();
    end
  endtask

  // Walks the program slot by slot, as a program would execute, checking every cycle.
  task automatic run(input bit loop, input bit smode, input int abort_at, input bit poke, input int pause_n);
    int p, n, cnt, w;
    bit fin;
    loop_en = loop; step_mode = smode;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0; n = 0; p = 0; fin = 1'b0;
    if (!m_valid[0]) begin
      expect_done(0, 0);
      return;
    end
    while (!fin) begin
      for (int k = 0; k < CYC; k++) begin
        check("instr", instruction, m_mem[p]);
        check("ivalid", instr_valid, 1);
        check("strobe", instr_strobe, (k == 0));
        check("pc", pc, p);
        check("busy", busy, 1);
        check("done_low", done, 0);
        check("count", instr_count, cnt);
        load_we = poke && (n == 0) && (k == 0);
        load_addr = 8'd5; load_data = 11'h555;
        if (n == abort_at && k == 1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0; load_we = 1'b0;
          expect_idle(cnt);
          return;
        end
        tick();
      end
      load_we = 1'b0;
      cnt = (cnt + 1) % (1 << CNT_W);
      n++;
      if (smode) begin
        w = (pause_n < 0) ? int'($urandom_range(0, 10)) : pause_n;
        for (int i = 0; i <= w; i++) begin
          check("pause_ivalid", instr_valid, 0);
          check("pause_instr", instruction, m_mem[p]);
          check("pause_pc", pc, p);
          check("pause_busy", busy, 1);
          check("pause_strobe", instr_strobe, 0);
          check("pause_count", instr_count, cnt);
          if (i < w) tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
      end
      if (p < DEPTH - 1 && m_valid[p + 1]) p++;
      else if (loop && m_valid[0]) p = 0;
      else begin
        expect_done(p, cnt);
        fin = 1'b1;
      end
      if (!fin && n > 700) begin
        check("run_bound", n, 700);
        abort = 1'b1; tick(); abort = 1'b0;
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    int len, hole, abort_at;
    bit lp, sm;
    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; clear_prog = 1'b0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; loop_en = 1'b0; abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_mem[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    expect_idle(0);
    reset = 1'b0;
    tick();

    // Three-slot program, free run, then loop with abort during the second pc 1.
    load(0, 11'h101); load(1, 11'h212); load(2, 11'h323);
    run(1'b0, 1'b0, -1, 1'b0, 0);
    run(1'b1, 1'b0, 4, 1'b0, 0);

    // Single-step two-slot program with a 10-cycle pause.
    clear_all();
    load(0, 11'h0AA); load(1, 11'h155);
    run(1'b0, 1'b1, -1, 1'b0, 10);

    // clear_prog beats load_we in the same cycle -> empty program.
    load_we = 1'b1; load_addr = 8'd0; load_data = 11'h7FF; clear_prog = 1'b1;
    tick();
    load_we = 1'b0; clear_prog = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    run(1'b0, 1'b0, -1, 1'b0, 0);

    // Write to slot 5 while busy must be dropped; rerun shows slot 5 still invalid.
    for (int i = 0; i < 5; i++) load(i, INSTR_W'($urandom_range(0, 2047)));
    run(1'b0, 1'b0, -1, 1'b1, 0);
    run(1'b0, 1'b0, -1, 1'b0, 0);

    // Full-depth program.
    for (int i = 0; i < DEPTH; i++) load(i, INSTR_W'($urandom_range(0, 2047)));
    run(1'b0, 1'b0, -1, 1'b0, 0);

    // Randomized programs, modes and aborts.
    for (int it = 0; it < 12; it++) begin
      clear_all();
      len = $urandom_range(1, 10);
      hole = $urandom_range(0, len + 3);
      for (int i = 0; i < len; i++)
        if (i != hole) load(i, INSTR_W'($urandom_range(0, 2047)));
      lp = 1'($urandom_range(0, 1));
      sm = ($urandom_range(0, 3) == 0);
      if (lp) abort_at = $urandom_range(0, 20);
      else abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run(lp, sm, abort_at, 1'b0, -1);
    end

    // Asynchronous reset mid-hold clears everything including valid bits.
    clear_all();
    load(0, 11'h101); load(1, 11'h212); load(2, 11'h323);
    loop_en = 1'b0; step_mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    expect_idle(0);
    #2 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    tick();
    run(1'b0, 1'b0, -1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
Synthesizable instruction sequencer feeding the cpu_top instruction port. It holds a loadable program memory and presents each instruction for exactly CYCLES_PER_INSTR clocks, matching the FETCH->EXEC->STORE cadence. Supports free-run, single-step and loop modes, and detects end of program from per-slot valid bits. It is the on-chip successor of the bench-driven program loop and sits between the host/GUI load path and cpu_top.

Parameters:
INSTR_W, 11, instruction width (opcode + operands)
DEPTH, 256, program slots; power of two, >= 2
PC_W, $clog2(DEPTH), program counter width
CYCLES_PER_INSTR, 3, clocks each instruction is held; >= 1
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load_we  in  1  program write strobe
load_addr  in  PC_W  program write address
load_data  in  INSTR_W  program write data
clear_prog  in  1  pulse: invalidate all slots
load_ready  out  1  high in IDLE/DONE; writes accepted only then
start  in  1  pulse: begin execution at pc 0
step_mode  in  1  level: pause after every instruction
step  in  1  pulse: release one instruction from PAUSE
loop_en  in  1  level: wrap to pc 0 at end of program
abort  in  1  pulse: return to IDLE
instruction  out  INSTR_W  registered instruction to cpu_top
instr_valid  out  1  high while instruction is being issued
instr_strobe  out  1  one-cycle pulse on first issue cycle of each instruction
pc  out  PC_W  address of current instruction
busy  out  1  state is ISSUE or PAUSE
done  out  1  state is DONE
instr_count  out  CNT_W  instructions retired since last start

Behaviour:
- Reset (async): state IDLE; instruction=0, instr_valid=0, instr_strobe=0, pc=0, busy=0, done=0, instr_count=0, load_ready=1, all valid bits cleared. Memory data not reset.
- Load: load_we && load_ready writes mem[load_addr]=load_data, sets valid[load_addr]. Ignored while busy. clear_prog && load_ready clears all valid bits in one cycle; clear_prog beats load_we in the same cycle.
- States: IDLE, ISSUE, PAUSE, DONE.
- IDLE/DONE + start: if valid[0], next cycle is ISSUE, pc=0, instruction=mem[0], instr_valid=1, instr_strobe=1, instr_count=0, done=0. If !valid[0], go to DONE, count 0.
- ISSUE: cycle counter 0..CYCLES_PER_INSTR-1; instruction stable throughout; strobe only on cycle 0. On the last cycle: instr_count += 1 (wraps at 2^CNT_W), then:
  - step_mode=1 -> PAUSE; instr_valid=0, instruction held.
  - else next = pc+1. If pc==DEPTH-1 or !valid[next]: loop_en && valid[0] -> ISSUE at pc 0, else DONE. Otherwise ISSUE at next. No idle gap between back-to-back instructions.
- PAUSE: step pulse applies the same next-pc decision as above. step outside PAUSE is ignored.
- DONE: done=1, instr_valid=0, instruction=0, pc holds the last executed address, instr_count holds.
- abort: from any state, next cycle is IDLE; outputs return to reset values except instr_count and memory/valid. abort beats start, step and end-of-cycle transitions.
- start while busy is ignored. Toggling step_mode takes effect at the next instruction boundary.
- Reset mid-operation: immediate IDLE; the program must be reloaded.

Decomposition:
- Shared package/header cpu_seq_defs: state encodings (SEQ_IDLE, SEQ_ISSUE, SEQ_PAUSE, SEQ_DONE) and the default INSTR_W. Opcode field macros stay in cpu_defs.
- One sub-module, seq_prog_mem: DEPTH x INSTR_W array with async read, write port and valid-bit vector with bulk clear. FSM and counters stay in the top.

Test Plan:
- Load 3 slots (0x101, 0x212, 0x323), CYCLES=3, start -> instruction shows each value for exactly 3 cycles, strobe at cycles 1/4/7 after start, done at cycle 10, instr_count=3.
- Same program, loop_en=1 -> sequence 0,1,2,0,1,2... with no gap; abort during pc 1 -> IDLE next cycle, instr_valid=0, instr_count=4.
- step_mode=1, 2-slot program -> PAUSE after slot 0; no progress for 10 cycles; step -> slot 1 issued next cycle; second step -> DONE.
- Empty program (clear_prog then start) -> DONE next cycle, instr_count=0, instr_valid never high.
- load_we to slot 5 while busy -> ignored (valid[5] still 0 after done). Full 256-slot program -> pc reaches 255, then DONE (loop_en=0).
- Assert reset during ISSUE mid-hold -> all outputs zero asynchronously; start afterward -> DONE immediately (valid bits cleared).
